// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
// FA_LATENCY follows the FULL_ADDER_REG_IN_EN build option.
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;

`ifdef FULL_ADDER_REG_IN_EN
  localparam int FA_LATENCY = 2;
`else
  localparam int FA_LATENCY = 1;
`endif

  // Sum is sized for the widest legal adder; narrower instances use the low WIDTH bits.
  typedef struct packed {
    logic [FA_MAX_WIDTH-1:0] sum;
    logic                    carry;
  } fa_result_t;

  function automatic bit fa_width_ok(input int w);
    return (w >= 1) && (w <= FA_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational one-bit full-adder cell: sum and majority carry.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-in/carry-out and a valid qualifier.
// Define FULL_ADDER_REG_IN_EN to add an input register stage (latency 2 instead of 1).
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             out_valid
);

  if (!fa_width_ok(WIDTH)) begin : g_width_check
    $error("full_adder: WIDTH must be in 1..64");
  end

  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic             core_c;
  logic             core_v;

`ifdef FULL_ADDER_REG_IN_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic             v_q;

  // Operands are captured every cycle; only the delayed valid decides acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      a_q <= a;
      b_q <= b;
      c_q <= c;
      v_q <= in_valid;
    end
  end

  assign core_a = a_q;
  assign core_b = b_q;
  assign core_c = c_q;
  assign core_v = v_q;
`else
  assign core_a = a;
  assign core_b = b;
  assign core_c = c;
  assign core_v = in_valid;
`endif

  // k[i] is the carry into bit i; k[WIDTH] is the carry-out of the whole chain.
  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] sum_n;

  assign k[0] = core_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_bit u_bit (
      .a_i    (core_a[i]),
      .b_i    (core_b[i]),
      .cin_i  (k[i]),
      .s_o    (sum_n[i]),
      .cout_o (k[i+1])
    );
  end

  fa_result_t res_d;
  fa_result_t res_q;
  logic       valid_q;

  always_comb begin
    res_d                 = '0;
    res_d.sum[WIDTH-1:0]  = sum_n;
    res_d.carry           = k[WIDTH];
  end

  // Result holds when no sample is accepted; out_valid is a one-cycle pulse per sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= core_v;
      if (core_v) begin
        res_q <= res_d;
      end
    end
  end

  assign s         = res_q.sum[WIDTH-1:0];
  assign co        = res_q.carry;
  assign out_valid = valid_q;

  logic unused_sum_bits;
  assign unused_sum_bits = ^res_q.sum;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: three instances (WIDTH 1, 4, 8) fed directed vectors.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk;
  logic rst;

  logic       v1, a1, b1, c1, s1, co1, ov1;
  logic       v4, c4, co4, ov4;
  logic [3:0] a4, b4, s4;
  logic       v8, c8, co8, ov8;
  logic [7:0] a8, b8, s8;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .s(s1), .co(co1), .out_valid(ov1)
  );
  full_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c(c4),
    .s(s4), .co(co4), .out_valid(ov4)
  );
  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .s(s8), .co(co8), .out_valid(ov8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp1_q[$];
  logic [4:0] exp4_q[$];
  logic [8:0] exp8_q[$];
  int         iss8_q[$];

  int pulses4 = 0;
  int run8    = 0;
  int max_run8 = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (ov1) begin
      if (exp1_q.size() == 0) check("dut1_unexpected_valid", 64'd1, 64'd0);
      else check("dut1_result", {62'd0, co1, s1}, {62'd0, exp1_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (ov4) begin
      pulses4++;
      if (exp4_q.size() == 0) check("dut4_unexpected_valid", 64'd1, 64'd0);
      else check("dut4_result", {59'd0, co4, s4}, {59'd0, exp4_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (ov8) begin
      run8++;
      if (run8 > max_run8) max_run8 = run8;
      if (exp8_q.size() == 0) check("dut8_unexpected_valid", 64'd1, 64'd0);
      else begin
        check("dut8_result", {55'd0, co8, s8}, {55'd0, exp8_q.pop_front()});
        check("dut8_latency", 64'(cyc - iss8_q.pop_front()), 64'(FA_LATENCY));
      end
    end else begin
      run8 = 0;
    end
  end

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic a, input logic b, input logic c, input logic [1:0] e);
    a1 = a; b1 = b; c1 = c; v1 = 1'b1;
    exp1_q.push_back(e);
    step();
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [4:0] e);
    a4 = a; b4 = b; c4 = c; v4 = 1'b1;
    exp4_q.push_back(e);
    step();
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] e);
    a8 = a; b8 = b; c8 = c; v8 = 1'b1;
    exp8_q.push_back(e);
    iss8_q.push_back(cyc);
    step();
  endtask

  task automatic idle_all();
    v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp1_q.size() + exp4_q.size() + exp8_q.size()) != 0 && n < 20) begin
      step();
      n++;
    end
    if ((exp1_q.size() + exp4_q.size() + exp8_q.size()) != 0)
      check("drain_timeout", 64'(exp1_q.size() + exp4_q.size() + exp8_q.size()), 64'd0);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s1"}, {63'd0, s1}, 64'd0);
    check({tag, "_co1"}, {63'd0, co1}, 64'd0);
    check({tag, "_ov1"}, {63'd0, ov1}, 64'd0);
    check({tag, "_s4"}, {60'd0, s4}, 64'd0);
    check({tag, "_ov4"}, {63'd0, ov4}, 64'd0);
    check({tag, "_s8"}, {56'd0, s8}, 64'd0);
    check({tag, "_co8"}, {63'd0, co8}, 64'd0);
    check({tag, "_ov8"}, {63'd0, ov8}, 64'd0);
  endtask

  // Hand-computed {co,s} for {a,b,c} = 0..7.
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    int         waited;

    rst = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v4 = 0; a4 = 0; b4 = 0; c4 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_init");
    rst = 1'b0;
    step();

    // WIDTH=1 truth table, back-to-back
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      send1(abc[2], abc[1], abc[0], tt[i]);
    end
    idle_all();
    drain();

    // WIDTH=4 ripple and maximum result; WIDTH=8 maximum result
    send4(4'hF, 4'h0, 1'b1, 5'h10);
    send4(4'h7, 4'h8, 1'b0, 5'h0F);
    send4(4'hF, 4'hF, 1'b1, 5'h1F);
    idle_all();
    send8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    idle_all();
    drain();

    // Hold: one accepted sample, then five idle cycles with changing operands
    pulses4 = 0;
    send4(4'h3, 4'h4, 1'b1, 5'h08);
    for (int k = 0; k < 5; k++) begin
      v4 = 1'b0;
      a4 = 4'(k + 9); b4 = 4'hF; c4 = 1'b1;
      @(negedge clk);
      if (k >= FA_LATENCY - 1) begin
        check("hold_s4", {60'd0, s4}, 64'h8);
        check("hold_co4", {63'd0, co4}, 64'd0);
      end
      step();
    end
    check("hold_pulse_count", 64'(pulses4), 64'd1);
    drain();

    // Back-to-back random stream of 100 WIDTH=8 samples
    max_run8 = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      send8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
    end
    idle_all();
    drain();
    check("stream_continuous_valid", 64'(max_run8), 64'd100);

    // Reset asserted mid-cycle while out_valid is high; this sample is discarded
    a8 = 8'hAA; b8 = 8'h01; c8 = 1'b1; v8 = 1'b1;
    step();
    v8 = 1'b0;
    waited = 0;
    while (!ov8 && waited < 4) begin
      step();
      waited++;
    end
    check("reset_prereq_ov8", {63'd0, ov8}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("reset_async");
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    step();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_released");
    step();

    // First sample after release is accepted normally
    send8(8'h12, 8'h34, 1'b0, 9'h046);
    idle_all();
    drain();

    check("final_queues_empty", 64'(exp1_q.size() + exp4_q.size() + exp8_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
